gmii_loop_fabric: RTL and testbench
===================================

// Module: gmii_loop_fabric
// PURPOSE
//  N-port GMII crossbar for tester loop systems. Each output port forwards one configurable input port.
//  Source changes take effect only at frame boundaries, so no frame is ever truncated or spliced.
//  Optional error injection per output; per-output frame, error-frame and dropped-frame counters.
//  Sits between traffic_generator_gmii / DUT / traffic_analyzer_gmii instances, all on one clk.
// PARAMETERS
//  C_NUM_PORTS   4   number of GMII inputs and outputs (2..16)
//  C_SEL_WIDTH   2   width of each source select field; >= clog2(C_NUM_PORTS)
//  C_CNT_WIDTH   32  width of each statistics counter
// PORTS
//  clk          in   1                    GMII/system clock; all logic on rising edge
//  resetn       in   1                    asynchronous, active-low reset
//  gmii_d_in    in   8*C_NUM_PORTS        input data; port p = [8p+7:8p]
//  gmii_en_in   in   C_NUM_PORTS          input data valid, per port
//  gmii_er_in   in   C_NUM_PORTS          input error, per port
//  gmii_d_out   out  8*C_NUM_PORTS        output data, registered
//  gmii_en_out  out  C_NUM_PORTS          output valid, registered
//  gmii_er_out  out  C_NUM_PORTS          output error, registered
//  cfg_sel      in   C_SEL_WIDTH*C_NUM_PORTS  source input index, per output
//  cfg_mode     in   2*C_NUM_PORTS        00 off, 01 forward, 10 forward+corrupt, 11 off
//  cnt_clear    in   1                    synchronous clear of all counters
//  frame_cnt    out  C_CNT_WIDTH*C_NUM_PORTS  frames forwarded, per output
//  err_cnt      out  C_CNT_WIDTH*C_NUM_PORTS  forwarded frames with er_out asserted on any byte
//  drop_cnt     out  C_CNT_WIDTH*C_NUM_PORTS  frames skipped because the source was mid-frame at lock
// BEHAVIOUR
//  - Reset (async, resetn=0): all gmii_*_out = 0. All counters = 0. All output FSMs go to IDLE.
//    en_prev[] = 0. This applies immediately, including mid-frame.
//  - en_prev[p]: gmii_en_in[p] registered one cycle. Rising edge of port p = en_in[p] & ~en_prev[p].
//  - One FSM per output o, with states IDLE, FWD, SKIP.
//  - IDLE:
//    - Latches act_sel[o] and act_mode[o] from cfg_* on every cycle.
//    - Outputs en=0, er=0, d=0.
//    - Effective mode is off if mode is 00 or 11, or if cfg_sel >= C_NUM_PORTS.
//    - Mode off: stay in IDLE.
//    - Source rising edge: go to FWD. The first byte appears on the output next cycle.
//    - Source en=1 and en_prev=1 (mid-frame): go to SKIP and increment drop_cnt.
//  - FWD:
//    - act_sel/act_mode are frozen; cfg changes are ignored.
//    - Each cycle: d_out <= d_in[s], en_out <= en_in[s], er_out <= er_in[s] | (mode==10 & en_in[s]).
//    - When source en_in=0: go to IDLE, increment frame_cnt, and increment err_cnt if any er_out=1
//      during the frame.
//  - SKIP: outputs stay idle. When source en_in=0, go to IDLE.
//  - Latency: exactly 1 clk from input byte to output byte, for every byte.
//    The IFG is preserved; a 1-cycle gap between frames is still forwarded as a 1-cycle gap.
//  - Back-to-back frames: FWD->IDLE on the en fall, then IDLE->FWD on the next rise.
//    No frame is lost at gap >= 1.
//  - Several outputs may select the same input (multicast). Outputs are independent.
//  - Counters wrap modulo 2^C_CNT_WIDTH.
//  - cnt_clear has priority over a same-cycle increment: the result is 0.
//  - cfg changes while in FWD apply only after the current frame ends.
//  - Setting an output to off mid-frame still completes that frame.
// TESTING
//  1 Reset: hold resetn=0 with port0 streaming -> all outputs 0, counters 0. Release -> forwarding
//    starts only at the next frame start.
//  2 Basic: out1 sel=0 mode=01; send 64-byte frame on in0 -> identical 64 bytes on out1, 1 clk later;
//    frame_cnt[1]=1, err_cnt[1]=0.
//  3 Corrupt: out2 sel=3 mode=10; 60-byte frame on in3 -> er_out[2]=1 for all 60 bytes;
//    frame_cnt[2]=1, err_cnt[2]=1.
//  4 Mid-frame lock: set out0 sel=1 mode=01 at byte 20 of a 100-byte frame on in1 -> that frame is not
//    output, drop_cnt[0]=1; the next frame is forwarded in full, frame_cnt[0]=1.
//  5 Reselect during frame: change out1 sel 0->2 at byte 10 of a frame on in0 -> the in0 frame
//    completes; the following in2 frame is forwarded; three back-to-back frames with gap=1 all counted.
//  6 Edge cases:
//    - cnt_clear on the same cycle as a frame end -> counter reads 0.
//    - sel=5 with C_NUM_PORTS=4 -> output stays idle.
//    - frame_cnt preloaded near 2^C_CNT_WIDTH-1 (or a test build with C_CNT_WIDTH=4, 16 frames)
//      -> wraps to 0.

Source files
------------

// File: rtl/gmii_loop_fabric.sv
// gmii_loop_fabric
//   N-port GMII crossbar for tester loop systems. Each output forwards one
//   selectable input. A source change only takes effect between frames, so
//   frames are never truncated or spliced. Outputs can optionally force
//   GMII error on every forwarded byte. Each output keeps frame, error-frame
//   and dropped-frame counters.
//
// Ports
//   clk, resetn      system clock, asynchronous active-low reset
//   gmii_*_in        per-port input data/valid/error (port p = [8p+7:8p])
//   gmii_*_out       per-port registered output data/valid/error
//   cfg_sel          source input index per output
//   cfg_mode         per output: 00 off, 01 forward, 10 forward+corrupt, 11 off
//   cnt_clear        synchronous clear of all counters (wins over increments)
//   frame_cnt        frames forwarded, per output
//   err_cnt          forwarded frames that carried er_out on any byte
//   drop_cnt         frames skipped because the source was mid-frame at lock
module gmii_loop_fabric #(
  parameter int C_NUM_PORTS = 4,
  parameter int C_SEL_WIDTH = 2,
  parameter int C_CNT_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [8*C_NUM_PORTS-1:0]           gmii_d_in,
  input  logic [C_NUM_PORTS-1:0]             gmii_en_in,
  input  logic [C_NUM_PORTS-1:0]             gmii_er_in,
  output logic [8*C_NUM_PORTS-1:0]           gmii_d_out,
  output logic [C_NUM_PORTS-1:0]             gmii_en_out,
  output logic [C_NUM_PORTS-1:0]             gmii_er_out,
  input  logic [C_SEL_WIDTH*C_NUM_PORTS-1:0] cfg_sel,
  input  logic [2*C_NUM_PORTS-1:0]           cfg_mode,
  input  logic                               cnt_clear,
  output logic [C_CNT_WIDTH*C_NUM_PORTS-1:0] frame_cnt,
  output logic [C_CNT_WIDTH*C_NUM_PORTS-1:0] err_cnt,
  output logic [C_CNT_WIDTH*C_NUM_PORTS-1:0] drop_cnt
);

  localparam int N = C_NUM_PORTS;
  localparam int S = C_SEL_WIDTH;
  localparam int W = C_CNT_WIDTH;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_SKIP = 2'd2
  } state_t;

  state_t         state_q    [N];
  logic [S-1:0]   act_sel_q  [N];
  logic [1:0]     act_mode_q [N];
  logic [7:0]     d_q        [N];
  logic [W-1:0]   frame_q    [N];
  logic [W-1:0]   err_q      [N];
  logic [W-1:0]   drop_q     [N];
  logic [N-1:0]   en_q, er_q, err_seen_q;
  logic [N-1:0]   en_prev_q;
  // Low only in the first cycle after reset: en_prev is 0 then, so a source
  // already streaming would look like a frame start. Treat it as mid-frame.
  logic           started_q;

  logic [S-1:0]   cur_sel  [N];
  logic [1:0]     cur_mode [N];
  logic [7:0]     src_d    [N];
  logic [N-1:0]   sel_ok, src_en, src_prev, src_er, mode_on, er_next;

  // In IDLE the live cfg drives the decision; otherwise the frozen copy.
  always_comb begin
    for (int o = 0; o < N; o++) begin
      cur_sel[o]  = (state_q[o] == S_IDLE) ? cfg_sel[S*o +: S]  : act_sel_q[o];
      cur_mode[o] = (state_q[o] == S_IDLE) ? cfg_mode[2*o +: 2] : act_mode_q[o];
      sel_ok[o]   = 1'b0;
      src_en[o]   = 1'b0;
      src_prev[o] = 1'b0;
      src_er[o]   = 1'b0;
      src_d[o]    = 8'h00;
      // Out-of-range selects match no port and leave sel_ok low.
      for (int p = 0; p < N; p++) begin
        if (cur_sel[o] == S'(p)) begin
          sel_ok[o]   = 1'b1;
          src_en[o]   = gmii_en_in[p];
          src_prev[o] = en_prev_q[p];
          src_er[o]   = gmii_er_in[p];
          src_d[o]    = gmii_d_in[8*p +: 8];
        end
      end
      mode_on[o] = sel_ok[o] & ((cur_mode[o] == 2'b01) | (cur_mode[o] == 2'b10));
      er_next[o] = src_er[o] | ((cur_mode[o] == 2'b10) & src_en[o]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en_prev_q  <= '0;
      started_q  <= 1'b0;
      en_q       <= '0;
      er_q       <= '0;
      err_seen_q <= '0;
      for (int o = 0; o < N; o++) begin
        state_q[o]    <= S_IDLE;
        act_sel_q[o]  <= '0;
        act_mode_q[o] <= 2'b00;
        d_q[o]        <= 8'h00;
        frame_q[o]    <= '0;
        err_q[o]      <= '0;
        drop_q[o]     <= '0;
      end
    end else begin
      en_prev_q <= gmii_en_in;
      started_q <= 1'b1;
      for (int o = 0; o < N; o++) begin
        case (state_q[o])
          S_IDLE: begin
            act_sel_q[o]  <= cfg_sel[S*o +: S];
            act_mode_q[o] <= cfg_mode[2*o +: 2];
            d_q[o]        <= 8'h00;
            en_q[o]       <= 1'b0;
            er_q[o]       <= 1'b0;
            err_seen_q[o] <= 1'b0;
            if (mode_on[o] && src_en[o]) begin
              if (!src_prev[o] && started_q) begin
                // Frame start: first byte goes out next cycle.
                state_q[o]    <= S_FWD;
                d_q[o]        <= src_d[o];
                en_q[o]       <= 1'b1;
                er_q[o]       <= er_next[o];
                err_seen_q[o] <= er_next[o];
              end else begin
                state_q[o] <= S_SKIP;
                drop_q[o]  <= drop_q[o] + CNT_ONE;
              end
            end
          end
          S_FWD: begin
            d_q[o]  <= src_d[o];
            en_q[o] <= src_en[o];
            er_q[o] <= er_next[o];
            if (src_en[o]) begin
              err_seen_q[o] <= err_seen_q[o] | er_next[o];
            end else begin
              state_q[o] <= S_IDLE;
              frame_q[o] <= frame_q[o] + CNT_ONE;
              if (err_seen_q[o]) err_q[o] <= err_q[o] + CNT_ONE;
            end
          end
          S_SKIP: begin
            d_q[o]  <= 8'h00;
            en_q[o] <= 1'b0;
            er_q[o] <= 1'b0;
            if (!src_en[o]) state_q[o] <= S_IDLE;
          end
          default: state_q[o] <= S_IDLE;
        endcase
        // Placed last so a clear overrides any same-cycle increment.
        if (cnt_clear) begin
          frame_q[o] <= '0;
          err_q[o]   <= '0;
          drop_q[o]  <= '0;
        end
      end
    end
  end

  always_comb begin
    gmii_en_out = en_q;
    gmii_er_out = er_q;
    gmii_d_out  = '0;
    frame_cnt   = '0;
    err_cnt     = '0;
    drop_cnt    = '0;
    for (int o = 0; o < N; o++) begin
      gmii_d_out[8*o +: 8] = d_q[o];
      frame_cnt[W*o +: W]  = frame_q[o];
      err_cnt[W*o +: W]    = err_q[o];
      drop_cnt[W*o +: W]   = drop_q[o];
    end
  end

endmodule

// File: tb/tb_gmii_loop_fabric.sv
module tb_gmii_loop_fabric;

  localparam int NP = 4;
  localparam int SW = 3;

  logic              clk;
  logic              resetn;
  logic [8*NP-1:0]   gmii_d_in;
  logic [NP-1:0]     gmii_en_in, gmii_er_in;
  logic [8*NP-1:0]   gmii_d_out;
  logic [NP-1:0]     gmii_en_out, gmii_er_out;
  logic [SW*NP-1:0]  cfg_sel;
  logic [2*NP-1:0]   cfg_mode;
  logic              cnt_clear;
  logic [32*NP-1:0]  frame_cnt, err_cnt, drop_cnt;

  logic [8*NP-1:0]   w_d_out;
  logic [NP-1:0]     w_en_out, w_er_out;
  logic [4*NP-1:0]   w_frame_cnt, w_err_cnt, w_drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  gmii_loop_fabric #(.C_NUM_PORTS(NP), .C_SEL_WIDTH(SW), .C_CNT_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .gmii_d_in(gmii_d_in), .gmii_en_in(gmii_en_in), .gmii_er_in(gmii_er_in),
    .gmii_d_out(gmii_d_out), .gmii_en_out(gmii_en_out), .gmii_er_out(gmii_er_out),
    .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .cnt_clear(cnt_clear),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  // Narrow-counter build to exercise counter wrap in 16 frames.
  gmii_loop_fabric #(.C_NUM_PORTS(NP), .C_SEL_WIDTH(SW), .C_CNT_WIDTH(4)) dut_w (
    .clk(clk), .resetn(resetn),
    .gmii_d_in(gmii_d_in), .gmii_en_in(gmii_en_in), .gmii_er_in(gmii_er_in),
    .gmii_d_out(w_d_out), .gmii_en_out(w_en_out), .gmii_er_out(w_er_out),
    .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .cnt_clear(cnt_clear),
    .frame_cnt(w_frame_cnt), .err_cnt(w_err_cnt), .drop_cnt(w_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int p, input logic en, input logic [7:0] d, input logic er);
    gmii_en_in[p]       = en;
    gmii_d_in[8*p +: 8] = d;
    gmii_er_in[p]       = er;
  endtask

  task automatic set_cfg(input int o, input int sel, input logic [1:0] mode);
    cfg_sel[SW*o +: SW] = SW'(sel);
    cfg_mode[2*o +: 2]  = mode;
  endtask

  function automatic logic [31:0] fcnt(input int o);
    return frame_cnt[32*o +: 32];
  endfunction
  function automatic logic [31:0] ecnt(input int o);
    return err_cnt[32*o +: 32];
  endfunction
  function automatic logic [31:0] dcnt(input int o);
    return drop_cnt[32*o +: 32];
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    set_cfg(0, 0, 2'b01);
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1'b1, 8'(8'hA0 + i), 1'b0);
      tick();
      n_cmp++;
      if (gmii_en_out !== '0 || gmii_d_out !== '0 || gmii_er_out !== '0 ||
          frame_cnt !== '0 || err_cnt !== '0 || drop_cnt !== '0) begin
        n_bad++;
        $display("FAIL reset_hold cyc %0d: en=%b er=%b d=%h required all zero",
                 i, gmii_en_out, gmii_er_out, gmii_d_out);
      end
    end
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_in(0, 1'b1, 8'(8'hB0 + i), 1'b0);
      tick();
      n_cmp++;
      if (gmii_en_out[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_tail cyc %0d: en_out0=%b required 0", i, gmii_en_out[0]);
      end
    end
    set_in(0, 1'b0, 8'h00, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1'b1, 8'(8'hC0 + i), 1'b0);
      tick();
      n_cmp++;
      if (gmii_en_out[0] !== 1'b1 || gmii_d_out[7:0] !== 8'(8'hC0 + i)) begin
        n_bad++;
        $display("FAIL reset_next byte %0d: en=%b d=%h required en=1 d=%h",
                 i, gmii_en_out[0], gmii_d_out[7:0], 8'(8'hC0 + i));
      end
    end
    set_in(0, 1'b0, 8'h00, 1'b0);
    tick();
    n_cmp++;
    if (fcnt(0) !== 32'd1) begin
      n_bad++;
      $display("FAIL reset_frame_cnt: got %0d required 1", fcnt(0));
    end
    set_in(0, 1'b1, 8'hD0, 1'b0);
    tick();
    n_cmp++;
    if (gmii_en_out[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_pre_async: en_out0=%b required 1", gmii_en_out[0]);
    end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (gmii_en_out !== '0 || gmii_d_out !== '0 || frame_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_async: en=%b d=%h fcnt0=%0d required all zero",
               gmii_en_out, gmii_d_out, fcnt(0));
    end
    set_in(0, 1'b0, 8'h00, 1'b0);
    set_cfg(0, 0, 2'b00);
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    set_cfg(1, 0, 2'b01);
    tick();
    for (int i = 0; i < 64; i++) begin
      set_in(0, 1'b1, 8'(i * 7 + 3), 1'b0);
      if (i == 0) begin
        n_cmp++;
        if (gmii_en_out[1] !== 1'b0) begin
          n_bad++;
          $display("FAIL basic_latency: en_out1=%b before clock edge, required 0", gmii_en_out[1]);
        end
      end
      tick();
      n_cmp++;
      if (gmii_en_out[1] !== 1'b1 || gmii_er_out[1] !== 1'b0 || gmii_d_out[15:8] !== 8'(i * 7 + 3)) begin
        n_bad++;
        $display("FAIL basic byte %0d: en=%b er=%b d=%h required en=1 er=0 d=%h",
                 i, gmii_en_out[1], gmii_er_out[1], gmii_d_out[15:8], 8'(i * 7 + 3));
      end
    end
    set_in(0, 1'b0, 8'h00, 1'b0);
    tick();
    n_cmp++;
    if (gmii_en_out[1] !== 1'b0 || fcnt(1) !== 32'd1 || ecnt(1) !== 32'd0) begin
      n_bad++;
      $display("FAIL basic_end: en=%b frame_cnt=%0d err_cnt=%0d required 0/1/0",
               gmii_en_out[1], fcnt(1), ecnt(1));
    end
  endtask

  task automatic test_corrupt();
    set_cfg(1, 0, 2'b00);
    set_cfg(2, 3, 2'b10);
    tick();
    for (int i = 0; i < 60; i++) begin
      set_in(3, 1'b1, 8'(8'h55 ^ i), 1'b0);
      tick();
      n_cmp++;
      if (gmii_en_out[2] !== 1'b1 || gmii_er_out[2] !== 1'b1 || gmii_d_out[23:16] !== 8'(8'h55 ^ i)) begin
        n_bad++;
        $display("FAIL corrupt byte %0d: en=%b er=%b d=%h required en=1 er=1 d=%h",
                 i, gmii_en_out[2], gmii_er_out[2], gmii_d_out[23:16], 8'(8'h55 ^ i));
      end
    end
    set_in(3, 1'b0, 8'h00, 1'b0);
    tick();
    n_cmp++;
    if (gmii_en_out[2] !== 1'b0 || gmii_er_out[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL corrupt_gap: en=%b er=%b required 0/0", gmii_en_out[2], gmii_er_out[2]);
    end
    n_cmp++;
    if (fcnt(2) !== 32'd1 || ecnt(2) !== 32'd1) begin
      n_bad++;
      $display("FAIL corrupt_cnt: frame_cnt=%0d err_cnt=%0d required 1/1", fcnt(2), ecnt(2));
    end
  endtask

  task automatic test_midframe_lock();
    set_cfg(2, 0, 2'b00);
    tick();
    for (int i = 0; i < 100; i++) begin
      set_in(1, 1'b1, 8'(i), 1'b0);
      if (i == 20) set_cfg(0, 1, 2'b01);
      tick();
      n_cmp++;
      if (gmii_en_out[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL lock_skip byte %0d: en_out0=%b required 0", i, gmii_en_out[0]);
      end
    end
    set_in(1, 1'b0, 8'h00, 1'b0);
    tick();
    n_cmp++;
    if (dcnt(0) !== 32'd1 || fcnt(0) !== 32'd0) begin
      n_bad++;
      $display("FAIL lock_drop: drop_cnt=%0d frame_cnt=%0d required 1/0", dcnt(0), fcnt(0));
    end
    tick();
    for (int i = 0; i < 30; i++) begin
      set_in(1, 1'b1, 8'(8'h80 + i), 1'b0);
      tick();
      n_cmp++;
      if (gmii_en_out[0] !== 1'b1 || gmii_d_out[7:0] !== 8'(8'h80 + i)) begin
        n_bad++;
        $display("FAIL lock_next byte %0d: en=%b d=%h required en=1 d=%h",
                 i, gmii_en_out[0], gmii_d_out[7:0], 8'(8'h80 + i));
      end
    end
    set_in(1, 1'b0, 8'h00, 1'b0);
    tick();
    n_cmp++;
    if (fcnt(0) !== 32'd1 || dcnt(0) !== 32'd1) begin
      n_bad++;
      $display("FAIL lock_cnt: frame_cnt=%0d drop_cnt=%0d required 1/1", fcnt(0), dcnt(0));
    end
  endtask

  task automatic test_back_to_back();
    set_cfg(0, 0, 2'b00);
    set_cfg(1, 0, 2'b01);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    n_cmp++;
    if (fcnt(1) !== 32'd0) begin
      n_bad++;
      $display("FAIL b2b_clear: frame_cnt=%0d required 0", fcnt(1));
    end
    for (int i = 0; i < 20; i++) begin
      set_in(0, 1'b1, 8'(8'h20 + i), 1'b0);
      if (i == 10) set_cfg(1, 2, 2'b01);
      tick();
      n_cmp++;
      if (gmii_en_out[1] !== 1'b1 || gmii_d_out[15:8] !== 8'(8'h20 + i)) begin
        n_bad++;
        $display("FAIL reselect byte %0d: en=%b d=%h required en=1 d=%h",
                 i, gmii_en_out[1], gmii_d_out[15:8], 8'(8'h20 + i));
      end
    end
    set_in(0, 1'b0, 8'h00, 1'b0);
    tick();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) begin
        set_in(2, 1'b1, 8'(8'h40 + 16 * f + i), 1'b0);
        tick();
        n_cmp++;
        if (gmii_en_out[1] !== 1'b1 || gmii_d_out[15:8] !== 8'(8'h40 + 16 * f + i)) begin
          n_bad++;
          $display("FAIL b2b frame %0d byte %0d: en=%b d=%h required en=1 d=%h",
                   f, i, gmii_en_out[1], gmii_d_out[15:8], 8'(8'h40 + 16 * f + i));
        end
      end
      set_in(2, 1'b0, 8'h00, 1'b0);
      tick();
      n_cmp++;
      if (gmii_en_out[1] !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_gap frame %0d: en=%b required 0", f, gmii_en_out[1]);
      end
    end
    n_cmp++;
    if (fcnt(1) !== 32'd4) begin
      n_bad++;
      $display("FAIL b2b_cnt: frame_cnt=%0d required 4", fcnt(1));
    end
  endtask

  task automatic test_edges();
    for (int i = 0; i < 5; i++) begin
      set_in(2, 1'b1, 8'(i), 1'b0);
      tick();
    end
    set_in(2, 1'b0, 8'h00, 1'b0);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    n_cmp++;
    if (fcnt(1) !== 32'd0) begin
      n_bad++;
      $display("FAIL clear_at_end: frame_cnt=%0d required 0", fcnt(1));
    end
    for (int i = 0; i < 3; i++) begin
      set_in(2, 1'b1, 8'(i), 1'b0);
      tick();
    end
    set_in(2, 1'b0, 8'h00, 1'b0);
    tick();
    n_cmp++;
    if (fcnt(1) !== 32'd1) begin
      n_bad++;
      $display("FAIL clear_resume: frame_cnt=%0d required 1", fcnt(1));
    end

    set_cfg(1, 0, 2'b00);
    set_cfg(3, 5, 2'b01);
    tick();
    for (int i = 0; i < 6; i++) begin
      set_in(1, 1'b1, 8'(8'hE0 + i), 1'b0);
      tick();
      n_cmp++;
      if (gmii_en_out !== '0) begin
        n_bad++;
        $display("FAIL sel_range byte %0d: en_out=%b required 0000", i, gmii_en_out);
      end
    end
    set_in(1, 1'b0, 8'h00, 1'b0);
    tick();
    n_cmp++;
    if (fcnt(3) !== 32'd0 || dcnt(3) !== 32'd0) begin
      n_bad++;
      $display("FAIL sel_range_cnt: frame_cnt=%0d drop_cnt=%0d required 0/0", fcnt(3), dcnt(3));
    end

    set_cfg(3, 0, 2'b00);
    set_cfg(0, 0, 2'b01);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    for (int f = 0; f < 16; f++) begin
      set_in(0, 1'b1, 8'(f), 1'b0);
      tick();
      set_in(0, 1'b1, 8'(f + 1), 1'b0);
      tick();
      set_in(0, 1'b0, 8'h00, 1'b0);
      tick();
      if (f == 14) begin
        n_cmp++;
        if (w_frame_cnt[3:0] !== 4'd15) begin
          n_bad++;
          $display("FAIL wrap_pre: narrow frame_cnt=%0d required 15", w_frame_cnt[3:0]);
        end
      end
    end
    n_cmp++;
    if (w_frame_cnt[3:0] !== 4'd0) begin
      n_bad++;
      $display("FAIL wrap: narrow frame_cnt=%0d required 0", w_frame_cnt[3:0]);
    end
    n_cmp++;
    if (fcnt(0) !== 32'd16) begin
      n_bad++;
      $display("FAIL wrap_wide: frame_cnt=%0d required 16", fcnt(0));
    end
  endtask

  initial begin
    resetn     = 1'b0;
    gmii_d_in  = '0;
    gmii_en_in = '0;
    gmii_er_in = '0;
    cfg_sel    = '0;
    cfg_mode   = '0;
    cnt_clear  = 1'b0;
    test_reset();
    test_basic();
    test_corrupt();
    test_midframe_lock();
    test_back_to_back();
    test_edges();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
